encoder_2to4: RTL and testbench

//   Registered 4-input to 2-bit binary encoder (one-hot/priority), named per legacy "2to4" convention.

---
 rtl/encoder_pkg.sv | 6 +
 rtl/encoder_2to4_if.sv | 28 ++
 rtl/encoder_prio_comb.sv | 22 ++
 rtl/encoder_2to4.sv | 30 +++
 tb/tb_encoder_2to4.sv | 98 +++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared widths and index type for the priority encoder
package encoder_pkg;
  localparam int ENC_IN_W = 4;
  localparam int ENC_OUT_W = 2;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;
endpackage

// File: rtl/encoder_2to4_if.sv
// encoder_2to4_if: request vector in, encoded index/flags out; multi only with ENCODER_ONEHOT_CHECK_EN
interface encoder_2to4_if import encoder_pkg::*; #(
  parameter int IN_W = ENC_IN_W,
  localparam int OUT_W = $clog2(IN_W)
);
  logic [IN_W-1:0] din;
  logic [OUT_W-1:0] y;
  logic valid;
`ifdef ENCODER_ONEHOT_CHECK_EN
  logic multi;
`endif
  modport master (
    output din,
    input y,
    input valid
`ifdef ENCODER_ONEHOT_CHECK_EN
    , input multi
`endif
  );
  modport slave (
    input din,
    output y,
    output valid
`ifdef ENCODER_ONEHOT_CHECK_EN
    , output multi
`endif
  );
endinterface

// File: rtl/encoder_prio_comb.sv
// encoder_prio_comb: combinational highest-index priority encode; multi output with ENCODER_ONEHOT_CHECK_EN
module encoder_prio_comb import encoder_pkg::*; #(
  parameter int IN_W = ENC_IN_W,
  localparam int OUT_W = $clog2(IN_W)
) (
  input logic [IN_W-1:0] din,
  output logic [OUT_W-1:0] idx,
  output logic any
`ifdef ENCODER_ONEHOT_CHECK_EN
  , output logic multi
`endif
);
  // later iterations overwrite earlier ones, so the highest set bit wins
  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++) idx = din[i] ? OUT_W'(i) : idx;
  end
  assign any = |din;
`ifdef ENCODER_ONEHOT_CHECK_EN
  assign multi = |(din & (din - IN_W'(1)));
`endif
endmodule

// File: rtl/encoder_2to4.sv
// encoder_2to4: registered priority encoder, 1-cycle latency; ENCODER_ONEHOT_CHECK_EN adds multi
module encoder_2to4 import encoder_pkg::*; #(
  parameter int IN_W = ENC_IN_W
) (
  input logic clk,
  input logic rst,
  encoder_2to4_if.slave bus
);
  localparam int OUT_W = $clog2(IN_W);
  logic [OUT_W-1:0] idx;
  logic any;
`ifdef ENCODER_ONEHOT_CHECK_EN
  logic multi;
`endif
  encoder_prio_comb #(.IN_W(IN_W)) u_comb (
    .din(bus.din),
    .idx(idx),
    .any(any)
`ifdef ENCODER_ONEHOT_CHECK_EN
    , .multi(multi)
`endif
  );
  always_ff @(posedge clk) begin
    bus.y <= rst ? '0 : idx;
    bus.valid <= rst ? 1'b0 : any;
`ifdef ENCODER_ONEHOT_CHECK_EN
    bus.multi <= rst ? 1'b0 : multi;
`endif
  end
endmodule

// File: tb/tb_encoder_2to4.sv
// tb_encoder_2to4: scoreboard bench for encoder_2to4, with or without ENCODER_ONEHOT_CHECK_EN
module tb_encoder_2to4;
  import encoder_pkg::*;
  typedef struct {
    string tag;
    enc_idx_t y;
    logic v;
    logic m;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  bit done = 1'b0;
  encoder_2to4_if #(.IN_W(4)) bus();
  encoder_2to4 #(.IN_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic exp_t model(input string tag, input logic r, input logic [3:0] d);
    exp_t e;
    e.tag = tag;
    e.y = r ? 2'd0 : d[3] ? 2'd3 : d[2] ? 2'd2 : d[1] ? 2'd1 : 2'd0;
    e.v = r ? 1'b0 : (d != 4'd0);
    e.m = r ? 1'b0 : ($countones(d) > 1);
    return e;
  endfunction
  task automatic drive(input string tag, input logic r, input logic [3:0] d, input enc_idx_t ey, input logic ev, input logic em);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.din = d;
    e.tag = tag;
    e.y = ey;
    e.v = ev;
    e.m = em;
    q.push_back(e);
  endtask
  task automatic drive_model(input string tag, input logic r, input logic [3:0] d);
    @(negedge clk);
    rst = r;
    bus.din = d;
    q.push_back(model(tag, r, d));
  endtask
  initial begin
    exp_t e;
    logic my;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_vec++;
`ifdef ENCODER_ONEHOT_CHECK_EN
        my = bus.multi;
`else
        my = e.m;
`endif
        if (bus.y !== e.y || bus.valid !== e.v || my !== e.m) begin
          n_err++;
          $display("FAIL %s: got y=%0d valid=%b multi=%b, want y=%0d valid=%b multi=%b",
                   e.tag, bus.y, bus.valid, my, e.y, e.v, e.m);
        end
      end
    end
  end
  initial begin
    logic [3:0] d;
    logic r;
    bus.din = 4'b1111;
    drive("rst_a", 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);
    drive("rst_b", 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0);
    drive("oh0", 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    drive("oh1", 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    drive("oh2", 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    drive("oh3", 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    drive("zero", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    drive("p0110", 1'b0, 4'b0110, 2'd2, 1'b1, 1'b1);
    drive("p1111", 1'b0, 4'b1111, 2'd3, 1'b1, 1'b1);
    drive("p0011", 1'b0, 4'b0011, 2'd1, 1'b1, 1'b1);
    drive("p1001", 1'b0, 4'b1001, 2'd3, 1'b1, 1'b1);
    drive("strm", 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    drive("mid_rst", 1'b1, 4'b1000, 2'd0, 1'b0, 1'b0);
    drive("rel_rst", 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    drive("zero2", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      d = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 31) == 0);
      drive_model("rand", r, d);
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
